// File: rtl/test_value_uart_tx.sv
// test_value_uart_tx: sends test_value as "HHHH\r\n" over a UART line whenever it changes or on force_send.
// Define TVTX_PARITY_EN to add an even-parity bit to every character frame.
module test_value_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] test_value,
  input  logic        force_send,
  output logic        tx,
  output logic        busy,
  output logic        msg_done
);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TVTX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t      r_state;
  logic [15:0] r_last_sent;
  logic [15:0] r_snap;
  logic [2:0]  r_char_idx;
  logic [2:0]  r_bit_idx;
  logic [15:0] r_baud_cnt;
  logic [3:0]  w_nib;
  logic [7:0]  w_char;
  logic        w_baud_end;
  logic        w_trig;
  always_comb begin
    w_nib = r_char_idx == 3'd0 ? r_snap[15:12] :
            r_char_idx == 3'd1 ? r_snap[11:8]  :
            r_char_idx == 3'd2 ? r_snap[7:4]   : r_snap[3:0];
    w_char = r_char_idx == 3'd4 ? 8'h0D :
             r_char_idx == 3'd5 ? 8'h0A :
             w_nib < 4'd10      ? 8'h30 + {4'h0, w_nib} : 8'h37 + {4'h0, w_nib};
    w_baud_end = r_baud_cnt == 16'(CLKS_PER_BIT - 1);
    w_trig = (test_value != r_last_sent) || force_send;
  end
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last_sent <= 16'h0;
      r_snap      <= 16'h0;
      r_char_idx  <= 3'd0;
      r_bit_idx   <= 3'd0;
      r_baud_cnt  <= 16'd0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      msg_done    <= 1'b0;
    end else begin
      msg_done   <= 1'b0;
      r_baud_cnt <= (r_state == IDLE || w_baud_end) ? 16'd0 : r_baud_cnt + 16'd1;
      case (r_state)
        IDLE: if (w_trig) begin
          r_snap      <= test_value;
          r_last_sent <= test_value;
          r_char_idx  <= 3'd0;
          r_state     <= START;
          tx          <= 1'b0;
          busy        <= 1'b1;
        end
        START: if (w_baud_end) begin
          r_state   <= DATA;
          r_bit_idx <= 3'd0;
          tx        <= w_char[0];
        end
        DATA: if (w_baud_end) begin
          r_bit_idx <= r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef TVTX_PARITY_EN
            r_state <= PARITY;
            tx      <= ^w_char;
`else
            r_state <= STOP;
            tx      <= 1'b1;
`endif
          end else
            tx <= w_char[r_bit_idx + 3'd1];
        end
`ifdef TVTX_PARITY_EN
        PARITY: if (w_baud_end) begin
          r_state <= STOP;
          tx      <= 1'b1;
        end
`endif
        STOP: if (w_baud_end) begin
          if (r_char_idx < 3'd5) begin
            r_char_idx <= r_char_idx + 3'd1;
            r_state    <= START;
            tx         <= 1'b0;
          end else begin
            r_state  <= IDLE;
            busy     <= 1'b0;
            msg_done <= 1'b1;
            tx       <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_test_value_uart_tx.sv
// tb_test_value_uart_tx: decodes the serial line with an independent receiver and compares against expected messages.
module tb_test_value_uart_tx;
  localparam int CPB = 4;
`ifdef TVTX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int MSG = 6 * FB * CPB;
  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] test_value = 16'h0;
  logic        force_send = 1'b0;
  logic        tx, busy, msg_done;
  int tests = 0, fails = 0, rx_err = 0;
  logic [7:0]  rx_q[$];
  logic [15:0] last_m = 16'h0;
  string hexd = "0123456789ABCDEF";
  typedef struct { logic [15:0] v; logic f; bit send; } vec_t;
  vec_t vecs[7];
  test_value_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .reset(reset), .test_value(test_value), .force_send(force_send),
    .tx(tx), .busy(busy), .msg_done(msg_done)
  );
  always #5 CLK = ~CLK;
  // independent line receiver: samples mid-bit and checks framing
  initial begin
    forever begin
      @(negedge CLK);
      if (!reset && tx === 1'b0) begin
        logic [7:0] d;
        bit ab;
        d = 8'h0;
        ab = 0;
        repeat (2) @(negedge CLK);
        if (reset) ab = 1;
        else if (tx !== 1'b0) rx_err++;
        for (int b = 0; b < FB - 1; b++) begin
          repeat (CPB) @(negedge CLK);
          if (reset) ab = 1;
          if (b < 8) d[b] = tx;
          else if (b == FB - 2) begin
            if (!ab && tx !== 1'b1) rx_err++;
          end else if (!ab && tx !== ^d) rx_err++;
        end
        if (!ab) rx_q.push_back(d);
        @(negedge CLK);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] msg_byte(input logic [15:0] v, input int i);
    int k;
    k = (v >> (12 - 4 * i)) & 15;
    return i < 4 ? hexd[k] : (i == 4 ? 8'h0D : 8'h0A);
  endfunction
  task automatic chk_msg(input string name, input int base, input logic [15:0] v);
    bit ok;
    ok = rx_q.size() >= base + 6;
    for (int i = 0; i < 6 && ok; i++) if (rx_q[base + i] !== msg_byte(v, i)) ok = 0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d bytes from index %0d, first=%0h, expected message for %04h", name,
               rx_q.size() - base, base, rx_q.size() > base ? rx_q[base] : 8'hxx, v);
    end
  endtask
  task automatic apply(input string name, input logic [15:0] v, input logic f, input bit exp);
    int base, bc, dc;
    base = rx_q.size();
    @(negedge CLK);
    test_value = v;
    force_send = f;
    @(negedge CLK);
    force_send = 1'b0;
    chk({name, "_busy0"}, {31'd0, busy}, {31'd0, exp});
    chk({name, "_tx0"}, {31'd0, tx}, {31'd0, !exp});
    bc = busy;
    dc = 0;
    for (int i = 0; i < MSG + 60; i++) begin
      @(negedge CLK);
      bc += busy;
      dc += msg_done;
    end
    chk({name, "_busycyc"}, bc, exp ? MSG : 0);
    chk({name, "_done"}, dc, exp ? 1 : 0);
    chk({name, "_nbytes"}, rx_q.size() - base, exp ? 6 : 0);
    if (exp) chk_msg({name, "_msg"}, base, v);
    if (exp) last_m = v;
  endtask
  initial begin
    int bad, base, dc;
    logic [15:0] v;
    logic f;
    bit pend;
    logic done_tx, done_busy, nxt_busy;
    vecs[0] = '{16'h1A2F, 1'b0, 1'b1};
    vecs[1] = '{16'h1A2F, 1'b1, 1'b1};
    vecs[2] = '{16'h1A2F, 1'b0, 1'b0};
    vecs[3] = '{16'hBEEF, 1'b1, 1'b1};
    vecs[4] = '{16'h0000, 1'b0, 1'b1};
    vecs[5] = '{16'h0000, 1'b0, 1'b0};
    vecs[6] = '{16'h0007, 1'b0, 1'b1};
    repeat (3) @(negedge CLK);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (tx !== 1'b1 || busy !== 1'b0 || msg_done !== 1'b0) bad++;
    end
    chk("idle_after_reset", bad, 0);
    chk("idle_nbytes", rx_q.size(), 0);
    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i].v, vecs[i].f, vecs[i].send);
    // coalescing: two changes during one message leave only the latest
    base = rx_q.size();
    @(negedge CLK);
    test_value = 16'h0100;
    repeat (50) @(negedge CLK);
    test_value = 16'h0001;
    repeat (50) @(negedge CLK);
    test_value = 16'h0002;
    dc = 0;
    pend = 0;
    done_tx = 0;
    done_busy = 1;
    nxt_busy = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge CLK);
      if (pend) begin
        nxt_busy = busy;
        pend = 0;
      end
      if (msg_done) begin
        if (dc == 0) begin
          done_tx = tx;
          done_busy = busy;
          pend = 1;
        end
        dc++;
      end
    end
    chk("coal_done", dc, 2);
    chk("coal_nbytes", rx_q.size() - base, 12);
    chk_msg("coal_first", base, 16'h0100);
    chk_msg("coal_second", base + 6, 16'h0002);
    chk("gap_tx", {31'd0, done_tx}, 32'd1);
    chk("gap_busy", {31'd0, done_busy}, 32'd0);
    chk("gap_restart", {31'd0, nxt_busy}, 32'd1);
    last_m = 16'h0002;
    for (int n = 0; n < 16; n++) begin
      v = ($urandom_range(0, 2) == 0) ? last_m : 16'($urandom);
      f = 1'($urandom_range(0, 1));
      apply($sformatf("rnd%0d", n), v, f, (v != last_m) || f);
    end
    // abort during character 2, data bit 3, with test_value already back at zero
    base = rx_q.size();
    @(negedge CLK);
    test_value = 16'h00AB;
    @(negedge CLK);
    test_value = 16'h0000;
    repeat (2 * FB * CPB + 4 * CPB + 1) @(negedge CLK);
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_reset_tx", {31'd0, tx}, 32'd1);
    chk("mid_reset_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge CLK);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (tx !== 1'b1 || busy !== 1'b0 || msg_done !== 1'b0) bad++;
    end
    chk("post_reset_quiet", bad, 0);
    chk("mid_nbytes", rx_q.size() - base, 2);
    chk("frame_errors", rx_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
